// File: rtl/icfo_polar_to_rect.sv
// icfo_polar_to_rect
// Rebuilds a complex sample from polar form with an iterative rotation-mode CORDIC,
// one micro-rotation per clock:
//   real_out = mag * cos(phase), imag_out = mag * sin(phase)
//
// Build option: define GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain
// (multiply by K = 19898/32768). Without it the outputs carry the gain (~1.64676) and
// the result is registered on the last rotation edge.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   request strobe, accepted only while rdy = 1
//   mag_in    in   WIDTH+1 bit unsigned magnitude
//   phase_in  in   PH_W bit two's complement phase, full scale = 2*pi
//   rdy       out  idle, a request can be accepted
//   real_out  out  signed in-phase result, held until the next result
//   imag_out  out  signed quadrature result, held until the next result
//   val       out  one-cycle pulse marking a new result
module icfo_polar_to_rect #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PH_W  = 16,
  parameter int unsigned ITER  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [WIDTH:0]          mag_in,
  input  logic [PH_W-1:0]         phase_in,
  output logic                    rdy,
  output logic signed [WIDTH-1:0] real_out,
  output logic signed [WIDTH-1:0] imag_out,
  output logic                    val
);

  // x/y: magnitude bits + sign + one bit of CORDIC gain growth.
  localparam int unsigned XW   = WIDTH + 3;
  // Wide enough to hold x times the 16-bit gain constant before rounding.
  localparam int unsigned PW   = XW + 17;
  localparam int unsigned CntW = 5;

  // The arctangent table is written for a 16-bit phase; rescale for other widths.
  localparam int PhShift = int'(PH_W) - 16;
  localparam int AtanShr = (PhShift < 0) ? -PhShift : 0;
  localparam int AtanShl = (PhShift > 0) ? PhShift : 0;
  localparam int AtanRnd = (1 << AtanShr) >> 1;

  localparam logic [PH_W-1:0] QuarterTurn = {2'b01, {(PH_W-2){1'b0}}};

  localparam logic signed [WIDTH-1:0] SatHi = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SatLo = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    LimHi = PW'(SatHi);
  localparam logic signed [PW-1:0]    LimLo = PW'(SatLo);

`ifdef GAIN_COMP_EN
  // K = 1/gain in Q1.15, and half an output LSB for round-half-up.
  localparam logic signed [PW-1:0] GainK   = PW'(19898);
  localparam logic signed [PW-1:0] HalfLsb = PW'(1 << 14);

  typedef enum logic [1:0] {StIdle, StRot, StScale} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRot} state_e;
`endif

  // round(atan(2^-i) * 2^16 / (2*pi))
  function automatic logic [PH_W-1:0] atan_lut(input logic [CntW-1:0] idx);
    int a16;
    case (idx)
      5'd0:    a16 = 8192;
      5'd1:    a16 = 4836;
      5'd2:    a16 = 2555;
      5'd3:    a16 = 1297;
      5'd4:    a16 = 651;
      5'd5:    a16 = 326;
      5'd6:    a16 = 163;
      5'd7:    a16 = 81;
      5'd8:    a16 = 41;
      5'd9:    a16 = 20;
      5'd10:   a16 = 10;
      5'd11:   a16 = 5;
      5'd12:   a16 = 3;
      5'd13:   a16 = 1;
      5'd14:   a16 = 1;
      default: a16 = 0;
    endcase
    return PH_W'(((a16 + AtanRnd) >> AtanShr) << AtanShl);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [PW-1:0] v);
    if (v > LimHi) begin
      return SatHi;
    end else if (v < LimLo) begin
      return SatLo;
    end
    return v[WIDTH-1:0];
  endfunction

`ifdef GAIN_COMP_EN
  function automatic logic signed [PW-1:0] scale_round(input logic signed [XW-1:0] v);
    return (PW'(v) * GainK + HalfLsb) >>> 15;
  endfunction
`endif

  state_e                  state_q;
  logic                    rdy_q;
  logic                    val_q;
  logic signed [WIDTH-1:0] real_q;
  logic signed [WIDTH-1:0] imag_q;
  logic signed [XW-1:0]    x_q;
  logic signed [XW-1:0]    y_q;
  logic [PH_W-1:0]         z_q;
  logic [CntW-1:0]         i_q;

  logic signed [XW-1:0]    mag_ext;
  logic signed [XW-1:0]    x_sh;
  logic signed [XW-1:0]    y_sh;
  logic signed [XW-1:0]    x_rot;
  logic signed [XW-1:0]    y_rot;
  logic [PH_W-1:0]         z_rot;
  logic [PH_W-1:0]         atan_i;

  assign mag_ext = $signed({2'b00, mag_in});

  // One micro-rotation; z >= 0 (including exactly 0) rotates counter-clockwise.
  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = atan_lut(i_q);
    if (!z_q[PH_W-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      real_q  <= '0;
      imag_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
    end else begin
      val_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ena) begin
            // Fold the angle into +/- pi/2 so the rotations can converge.
            case (phase_in[PH_W-1 -: 2])
              2'b01: begin
                x_q <= '0;
                y_q <= mag_ext;
                z_q <= phase_in - QuarterTurn;
              end
              2'b10: begin
                x_q <= '0;
                y_q <= -mag_ext;
                z_q <= phase_in + QuarterTurn;
              end
              default: begin
                x_q <= mag_ext;
                y_q <= '0;
                z_q <= phase_in;
              end
            endcase
            i_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= StRot;
          end
        end

        StRot: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          i_q <= i_q + CntW'(1);
          if (i_q == CntW'(ITER - 1)) begin
`ifdef GAIN_COMP_EN
            state_q <= StScale;
`else
            // x/y carry no fractional bits here, so only saturation applies.
            real_q  <= sat_out(PW'(x_rot));
            imag_q  <= sat_out(PW'(y_rot));
            val_q   <= 1'b1;
            rdy_q   <= 1'b1;
            state_q <= StIdle;
`endif
          end
        end

`ifdef GAIN_COMP_EN
        StScale: begin
          real_q  <= sat_out(scale_round(x_q));
          imag_q  <= sat_out(scale_round(y_q));
          val_q   <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= StIdle;
        end
`endif

        default: begin
          rdy_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rdy      = rdy_q;
  assign val      = val_q;
  assign real_out = real_q;
  assign imag_out = imag_q;

endmodule
